// File: rtl/dino_pkg.sv
// dino_pkg: state encoding, jump phase type and coordinate widths shared by the dino runner.
package dino_pkg;
    localparam int X_W = 7;
    localparam int Y_W = 6;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} phase_t;
endpackage

// File: rtl/dino_game_fsm_rise_edge.sv
// rise_edge: registered rising-edge detector for the debounced jump button.
module rise_edge (
    input  logic clk,
    input  logic Rst,
    input  logic din,
    output logic rise
);
    logic prev;
    always_ff @(posedge clk) begin
        prev <= Rst ? 1'b0 : din;
        rise <= Rst ? 1'b0 : din & ~prev;
    end
endmodule

// File: rtl/dino_game_fsm.sv
// dino_game_fsm: dino runner game-state FSM with jump trajectory, obstacle scroll and collision detect.
// Define DINO_SPEEDUP_EN to double the scroll step after 15 obstacle wraps.
module dino_game_fsm
    import dino_pkg::*;
#(
    parameter int SCREEN_W = 128,
    parameter int DINO_X   = 16,
    parameter int DINO_W   = 8,
    parameter int OBST_W   = 6,
    parameter int OBST_H   = 10,
    parameter int JUMP_H   = 20
) (
    input  logic           clk,
    input  logic           Rst,
    input  logic           tick,
    input  logic           btn_jump,
    output logic           stop,
    output logic [1:0]     state_o,
    output logic [Y_W-1:0] dino_y,
    output logic [X_W-1:0] obst_x,
    output logic           pass,
    output logic           dead,
    output logic           clr_score
);
    state_t         state;
    phase_t         phase;
    logic           pending;
    logic           btn_edge;
    logic           hit;
    logic [X_W-1:0] step;
    rise_edge u_rise (.clk(clk), .Rst(Rst), .din(btn_jump), .rise(btn_edge));
    assign state_o = state;
    // 8-bit compare so obst_x + OBST_W cannot wrap near the right edge
    assign hit = (({1'b0, obst_x} + 8'(OBST_W)) > 8'(DINO_X))
              && ({1'b0, obst_x} < 8'(DINO_X + DINO_W))
              && (dino_y < Y_W'(OBST_H));
`ifdef DINO_SPEEDUP_EN
    logic [3:0] wraps;
    assign step = (&wraps) ? X_W'(2) : X_W'(1);
    always_ff @(posedge clk)
        if (Rst || (state == IDLE && btn_edge))
            wraps <= '0;
        else if (state == RUN && tick && !hit && obst_x < step && !(&wraps))
            wraps <= wraps + 4'd1;
`else
    assign step = X_W'(1);
`endif
    always_ff @(posedge clk) begin
        pass      <= 1'b0;
        dead      <= 1'b0;
        clr_score <= 1'b0;
        if (Rst) begin
            state   <= IDLE;
            stop    <= 1'b1;
            dino_y  <= '0;
            obst_x  <= X_W'(SCREEN_W - 1);
            phase   <= UP;
            pending <= 1'b0;
        end else begin
            case (state)
                IDLE: if (btn_edge) begin
                    state   <= RUN;
                    stop    <= 1'b0;
                    obst_x  <= X_W'(SCREEN_W - 1);
                    dino_y  <= '0;
                    phase   <= UP;
                    pending <= 1'b0;
                end
                RUN: if (tick) begin
                    // an edge coincident with this tick is only seen on the next one
                    pending <= btn_edge;
                    if (hit) begin
                        state <= DEAD;
                        stop  <= 1'b1;
                        dead  <= 1'b1;
                    end else begin
                        if (obst_x < step) begin
                            obst_x <= X_W'(SCREEN_W - 1);
                            pass   <= 1'b1;
                        end else
                            obst_x <= obst_x - step;
                        if (dino_y == '0) begin
                            if (pending) begin
                                dino_y <= Y_W'(1);
                                phase  <= (JUMP_H == 1) ? DOWN : UP;
                            end
                        end else if (phase == UP) begin
                            dino_y <= dino_y + Y_W'(1);
                            if (dino_y + Y_W'(1) == Y_W'(JUMP_H))
                                phase <= DOWN;
                        end else
                            dino_y <= dino_y - Y_W'(1);
                    end
                end else if (btn_edge)
                    pending <= 1'b1;
                DEAD: if (btn_edge) begin
                    state     <= IDLE;
                    clr_score <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dino_game_fsm.sv
// tb_dino_game_fsm: random and directed stimulus checked every cycle against a behavioural game model.
module tb_dino_game_fsm;
    localparam int JH = 20;
`ifdef DINO_SPEEDUP_EN
    localparam bit SPEED = 1'b1;
`else
    localparam bit SPEED = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_jump = 1'b0;
    logic       stop, pass, dead, clr_score;
    logic [1:0] state_o;
    logic [5:0] dino_y;
    logic [6:0] obst_x;
    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    // model: state 0/1/2, airborne time m_t (0 = on ground), obstacle x as plain integer
    int m_state = 0, m_x = 127, m_t = 0, m_wraps = 0;
    bit m_pend = 0, m_prev = 0, m_edge = 0, m_pass = 0, m_dead = 0, m_clr = 0;

    dino_game_fsm dut (
        .clk(clk), .Rst(Rst), .tick(tick), .btn_jump(btn_jump),
        .stop(stop), .state_o(state_o), .dino_y(dino_y), .obst_x(obst_x),
        .pass(pass), .dead(dead), .clr_score(clr_score)
    );

    always #5 clk = ~clk;

    function automatic int ht(input int t);
        return (t <= JH) ? t : 2 * JH - t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int y, stp;
        bit e, hit;
        e = m_edge;
        m_edge = btn_jump & ~m_prev;
        m_prev = btn_jump;
        m_pass = 0; m_dead = 0; m_clr = 0;
        if (Rst) begin
            m_state = 0; m_x = 127; m_t = 0; m_pend = 0; m_wraps = 0; m_edge = 0; m_prev = 0;
        end else if (m_state == 0) begin
            if (e) begin m_state = 1; m_x = 127; m_t = 0; m_pend = 0; m_wraps = 0; end
        end else if (m_state == 2) begin
            if (e) begin m_state = 0; m_clr = 1; end
        end else if (tick) begin
            y = ht(m_t);
            hit = (m_x + 6 > 16) && (m_x < 24) && (y < 10);
            if (hit) begin
                m_state = 2; m_dead = 1;
            end else begin
                stp = (SPEED && m_wraps >= 15) ? 2 : 1;
                if (m_x < stp) begin
                    m_x = 127; m_pass = 1;
                    if (m_wraps < 15) m_wraps++;
                end else m_x -= stp;
                if (m_t > 0) m_t = (m_t + 1 == 2 * JH) ? 0 : m_t + 1;
                else if (m_pend) m_t = 1;
            end
            m_pend = e;
        end else if (e) m_pend = 1;
    end

    always @(negedge clk) if (chk_en) begin
        chk("stop", stop, int'(m_state != 1));
        chk("state_o", state_o, m_state);
        chk("dino_y", dino_y, ht(m_t));
        chk("obst_x", obst_x, m_x);
        chk("pass", pass, m_pass);
        chk("dead", dead, m_dead);
        chk("clr_score", clr_score, m_clr);
    end

    task automatic step_clk(input bit t, input bit b);
        tick = t;
        btn_jump = b;
        @(negedge clk);
    endtask

    task automatic press();
        step_clk(0, 1);
        step_clk(0, 0);
    endtask

    function automatic bit ap_btn();
        int tgt;
        tgt = (SPEED && m_wraps >= 15) ? 60 : 39;
        if (m_state != 1) return !btn_jump;
        if (m_t == 0 && m_x <= tgt && m_x >= tgt - 3) return !btn_jump;
        return 1'b0;
    endfunction

    initial begin
        bit found;
        @(negedge clk);
        step_clk(0, 0);
        step_clk(0, 0);
        Rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_stop", stop, 1);
        chk("rst_state", state_o, 0);
        chk("rst_x", obst_x, 127);
        chk("rst_y", dino_y, 0);
        chk("rst_pulses", {pass, dead, clr_score}, 0);
        press();
        chk("start_state", state_o, 1);
        repeat (104) step_clk(1, 0);
        chk("scroll_x23", obst_x, 23);
        step_clk(1, 0);
        chk("hit_dead", dead, 1);
        chk("hit_state", state_o, 2);
        chk("hit_x", obst_x, 23);
        step_clk(1, 0);
        chk("dead_frozen_x", obst_x, 23);
        chk("dead_pulse_end", dead, 0);
        press();
        chk("clr_pulse", clr_score, 1);
        chk("clr_state", state_o, 0);
        press();
        chk("restart_state", state_o, 1);
        chk("restart_x", obst_x, 127);
        repeat (87) step_clk(1, 0);
        chk("jump_x40", obst_x, 40);
        press();
        repeat (20) step_clk(1, 0);
        chk("apex_y", dino_y, 20);
        repeat (20) step_clk(1, 0);
        chk("land_y", dino_y, 0);
        chk("land_x", obst_x, 0);
        step_clk(1, 0);
        chk("wrap_pass", pass, 1);
        chk("wrap_x", obst_x, 127);
        press();
        repeat (5) step_clk(1, 0);
        chk("air_y5", dino_y, 5);
        press();
        repeat (15) step_clk(1, 0);
        chk("ignored_apex", dino_y, 20);
        repeat (21) step_clk(1, 0);
        chk("ignored_ground", dino_y, 0);
        chk("ignored_state", state_o, 1);
        repeat (2700) step_clk(1, ap_btn());
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (obst_x == 99 && state_o == 1) begin found = 1'b1; break; end
            step_clk(1, ap_btn());
        end
        chk("found_x99", found, 1);
        step_clk(1, 0);
        chk("step_after_play", obst_x, SPEED ? 97 : 98);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (state_o == 2) begin found = 1'b1; break; end
            step_clk(1, 0);
        end
        chk("found_dead", found, 1);
        press();
        press();
        chk("rerun_x", obst_x, 127);
        step_clk(1, 0);
        chk("rerun_step1", obst_x, 126);
        for (int i = 0; i < 3000; i++) begin
            Rst = ($urandom_range(0, 299) == 0);
            step_clk(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0) ? !btn_jump : btn_jump);
        end
        Rst = 1'b0;
        step_clk(0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
